// File: rtl/timer_capture.sv
// Input-capture peripheral: measures pulse width or period on cap_in in prescaled ticks and raises a level irq when done.
// Pin-to-FSM latency is 2 cycles; the register bus has no backpressure (single-cycle write, combinational read).
module timer_capture #(
    parameter int unsigned F_DIV = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    input  logic        cap_in,
    output logic        irq
);

    localparam int PW = (F_DIV > 1) ? $clog2(F_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MEAS,
        S_DONE
    } state_t;

    logic          s1_q, s2_q, s3_q;
    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          ie_q, ie_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          irq_q;
    logic [31:0]   cap_q, cap_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;

    logic        rise, fall, end_evt, tick;
    logic        cnt_max, tmo_hit, wrap_hit, busy;
    logic        ctrl_wr, tmo_wr;
    logic [31:0] cnt_inc;
    logic [31:0] status;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign end_evt = mode_q ? rise : fall;
    assign tick    = (pre_q == PW'(F_DIV - 1));

    assign cnt_inc  = cnt_q + 32'd1;
    assign cnt_max  = &cnt_q;
    assign tmo_hit  = tick && (tmo_q != 32'd0) && (cnt_inc == tmo_q);
    assign wrap_hit = tick && (tmo_q == 32'd0) && cnt_max;

    assign ctrl_wr = WE && (A == 2'd0);
    assign tmo_wr  = WE && (A == 2'd2);

    assign busy   = (state_q == S_WAIT) || (state_q == S_MEAS);
    assign status = {27'd0, ie_q, mode_q, ovf_q, done_q, busy};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ie_d    = ie_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        cap_d   = cap_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;

        case (state_q)
            S_WAIT: begin
                if (rise) begin
                    state_d = S_MEAS;
                    pre_d   = '0;
                    cnt_d   = 32'd0;
                end
            end
            S_MEAS: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick && !cnt_max) begin
                    cnt_d = cnt_inc;
                end
                // An end event outranks a timeout landing on the same tick.
                if (end_evt) begin
                    cap_d   = (tick && cnt_max) ? 32'hFFFF_FFFF : cnt_q + {31'd0, tick};
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    cap_d   = tmo_q;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else if (wrap_hit) begin
                    cap_d   = 32'hFFFF_FFFF;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
            end
        endcase

        // A CTRL write overrides whatever the FSM decided this cycle; a result landing now is dropped.
        if (ctrl_wr) begin
            mode_d = WD[1];
            ie_d   = WD[4];
            if (WD[0]) begin
                state_d = S_WAIT;
                done_d  = 1'b0;
                ovf_d   = 1'b0;
                cap_d   = cap_q;
                cnt_d   = 32'd0;
                pre_d   = '0;
            end else if (WD[2]) begin
                state_d = S_IDLE;
                done_d  = done_q;
                ovf_d   = ovf_q;
                cap_d   = cap_q;
            end
        end

        if (tmo_wr) begin
            tmo_d = WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            cap_q   <= 32'd0;
            tmo_q   <= 32'd0;
            cnt_q   <= 32'd0;
            pre_q   <= '0;
        end else begin
            s1_q    <= cap_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            mode_q  <= mode_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            irq_q   <= done_q & ie_q;
            cap_q   <= cap_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        RD = 32'd0;
        case (A)
            2'd0:    RD = status;
            2'd1:    RD = cap_q;
            2'd2:    RD = tmo_q;
            default: RD = cnt_q;
        endcase
    end

    assign irq = irq_q;

endmodule
